// File: rtl/dmem_mmio.sv
// dmem_mmio -- data-memory stage behind the single-cycle RV32I datapath.
//
// Decodes a byte address into a word-addressed RAM and an MMIO window.
// The MMIO window holds a free-running 64-bit timer with a compare-match
// interrupt, a 32-bit output port and a status word.
//
// Build option: define DMEM_TIMER_EN to include mtime/mtimecmp/irq. When it
// is undefined, the timer offsets read 0, writes to them are dropped and irq
// is tied low.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   MemWrite   store strobe
//   Addr       byte address (ALUResult)
//   WriteData  full 32-bit store word (already byte/half merged upstream)
//   ReadData   combinational read word for Addr
//   gpio_out   MMIO output port register
//   irq        registered timer interrupt (mtime >= mtimecmp)
module dmem_mmio #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [7:0] OFF_MTIME_LO = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI = 8'h04;
    localparam logic [7:0] OFF_CMP_LO   = 8'h08;
    localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
    localparam logic [7:0] OFF_GPIO     = 8'h10;
    localparam logic [7:0] OFF_STATUS   = 8'h14;

    logic [31:0]   mem [DEPTH_WORDS];
    logic          mmio_sel;
    logic [AW-1:0] ram_idx;
    logic [7:0]    mmio_off;
    logic          ram_we;
    logic          mmio_we;
    logic [31:0]   mmio_rdata;
    logic [31:0]   gpio_q;
    logic [31:0]   gpio_d;
    logic          unused_addr;

    assign mmio_sel    = (Addr[31:28] == MMIO_BASE[31:28]);
    assign ram_idx     = Addr[AW+1:2];
    assign mmio_off    = Addr[7:0];
    assign ram_we      = MemWrite && !mmio_sel;
    assign mmio_we     = MemWrite && mmio_sel;
    // Addr[27:8], the RAM alias bits and Addr[1:0] are deliberately ignored.
    assign unused_addr = ^Addr;

    // RAM has no reset value; reset only blocks a store that lands while it
    // is asserted so the contents survive a mid-operation reset.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset && ram_we) begin
            mem[ram_idx] <= WriteData;
        end
    end

    always_comb begin
        gpio_d = gpio_q;
        if (mmio_we && (mmio_off == OFF_GPIO)) begin
            gpio_d = WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q <= '0;
        end else begin
            gpio_q <= gpio_d;
        end
    end

    assign gpio_out = gpio_q;

`ifdef DMEM_TIMER_EN
    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtimecmp_d;
    logic        irq_q;

    // A write to either mtime half replaces that cycle's increment.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (mmio_we) begin
            case (mmio_off)
                OFF_MTIME_LO: mtime_d    = {mtime_q[63:32], WriteData};
                OFF_MTIME_HI: mtime_d    = {WriteData, mtime_q[31:0]};
                OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], WriteData};
                OFF_CMP_HI:   mtimecmp_d = {WriteData, mtimecmp_q[31:0]};
                default:      ;
            endcase
        end
    end

    // irq compares the current register values, so it trails them by a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            OFF_GPIO:     mmio_rdata = gpio_q;
`ifdef DMEM_TIMER_EN
            OFF_MTIME_LO: mmio_rdata = mtime_q[31:0];
            OFF_MTIME_HI: mmio_rdata = mtime_q[63:32];
            OFF_CMP_LO:   mmio_rdata = mtimecmp_q[31:0];
            OFF_CMP_HI:   mmio_rdata = mtimecmp_q[63:32];
            OFF_STATUS:   mmio_rdata = {31'd0, irq_q};
`endif
            default:      mmio_rdata = '0;
        endcase
    end

    always_comb begin
        ReadData = mem[ram_idx];
        if (mmio_sel) begin
            ReadData = mmio_rdata;
        end
    end

endmodule
